// File: rtl/mul_add_row_ctrl_if.sv
// mul_add_row_ctrl_if: row request, operand/result RAM ports and mul_add datapath of one row engine.
interface mul_add_row_ctrl_if #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 5
);
   logic start, t_en, busy, done, a_rd_en, t_rd_en, r_we;
   logic [DATA_WIDTH-1:0] b_word, carry_out, a_rdata, t_rdata;
   logic [DATA_WIDTH-1:0] ma_x, ma_y, ma_z, ma_last_c, ma_s, ma_c, r_wdata;
   logic [ADDR_WIDTH-1:0] a_addr, t_addr, r_addr;
   modport master (
      input  start, t_en, b_word, a_rdata, t_rdata, ma_s, ma_c,
      output busy, done, carry_out, a_rd_en, a_addr, t_rd_en, t_addr,
             ma_x, ma_y, ma_z, ma_last_c, r_we, r_addr, r_wdata
   );
   modport slave (
      output start, t_en, b_word, a_rdata, t_rdata, ma_s, ma_c,
      input  busy, done, carry_out, a_rd_en, a_addr, t_rd_en, t_addr,
             ma_x, ma_y, ma_z, ma_last_c, r_we, r_addr, r_wdata
   );
endinterface

// File: rtl/mul_add_row_ctrl.sv
// mul_add_row_ctrl: word-serial R = A*b + T row sequencer driving one external mul_add.
module mul_add_row_ctrl #(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_WORDS  = 16,
   parameter int ADDR_WIDTH = 5
) (
   input logic clk,
   input logic rst_n,
   mul_add_row_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINAL} state_t;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] TOP  = ADDR_WIDTH'(NUM_WORDS);
   state_t state, state_nxt;
   logic [DATA_WIDTH-1:0] b_reg, carry_reg, carry_out_q;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic t_en_reg, done_q, proc;
   // a word is processed one cycle after its read was issued
   assign proc = (state == DRAIN) || (state == RUN && rd_idx != '0);
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = bus.start ? RUN : IDLE;
         RUN:     state_nxt = (rd_idx == LAST) ? DRAIN : RUN;
         DRAIN:   state_nxt = FINAL;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         b_reg       <= '0;
         t_en_reg    <= 1'b0;
         carry_reg   <= '0;
         carry_out_q <= '0;
         rd_idx      <= '0;
         done_q      <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == FINAL);
         if (state == IDLE && bus.start) begin
            b_reg     <= bus.b_word;
            t_en_reg  <= bus.t_en;
            carry_reg <= '0;
            rd_idx    <= '0;
         end
         if (state == RUN) rd_idx <= rd_idx + 1'b1;
         if (proc) carry_reg <= bus.ma_c;
         if (state == FINAL) carry_out_q <= carry_reg;
      end
   end
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.carry_out = carry_out_q;
   assign bus.a_rd_en   = (state == RUN);
   assign bus.a_addr    = rd_idx;
   assign bus.t_rd_en   = (state == RUN) && t_en_reg;
   assign bus.t_addr    = rd_idx;
   assign bus.ma_x      = bus.a_rdata;
   assign bus.ma_y      = b_reg;
   assign bus.ma_z      = t_en_reg ? bus.t_rdata : '0;
   assign bus.ma_last_c = carry_reg;
   assign bus.r_we      = proc || (state == FINAL);
   assign bus.r_addr    = (state == FINAL) ? TOP : rd_idx - 1'b1;
   assign bus.r_wdata   = (state == FINAL) ? carry_reg : bus.ma_s;
endmodule

// File: tb/tb_mul_add_row_ctrl.sv
// tb_mul_add_row_ctrl: directed and random rows on N=4 and N=2 engines with RAM and mul_add models.
module tb_mul_add_row_ctrl;
   localparam int W = 128;
   localparam int N = 4;
   localparam logic [W-1:0] M = {W{1'b1}};
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   logic [N*W-1:0] A4, T4;
   logic [2*W-1:0] A2, T2;
   always #5 clk = ~clk;
   mul_add_row_ctrl_if #(.DATA_WIDTH(W), .ADDR_WIDTH(5)) i4 ();
   mul_add_row_ctrl_if #(.DATA_WIDTH(W), .ADDR_WIDTH(2)) i2 ();
   mul_add_row_ctrl #(.DATA_WIDTH(W), .NUM_WORDS(N), .ADDR_WIDTH(5)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.master));
   mul_add_row_ctrl #(.DATA_WIDTH(W), .NUM_WORDS(2), .ADDR_WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2.master));
   function automatic logic [2*W-1:0] mac(input logic [W-1:0] x, y, z, c);
      logic [2*W-1:0] xw, yw, zw, cw;
      xw = x; yw = y; zw = z; cw = c;
      return xw * yw + zw + cw;
   endfunction
   assign {i4.ma_c, i4.ma_s} = mac(i4.ma_x, i4.ma_y, i4.ma_z, i4.ma_last_c);
   assign {i2.ma_c, i2.ma_s} = mac(i2.ma_x, i2.ma_y, i2.ma_z, i2.ma_last_c);
   always @(posedge clk) begin
      if (i4.a_rd_en) i4.a_rdata <= A4[int'(i4.a_addr)*W +: W];
      if (i4.t_rd_en) i4.t_rdata <= T4[int'(i4.t_addr)*W +: W];
      if (i2.a_rd_en) i2.a_rdata <= A2[int'(i2.a_addr)*W +: W];
      if (i2.t_rd_en) i2.t_rdata <= T2[int'(i2.t_addr)*W +: W];
   end
   task automatic check(input string tag, input logic [(N+1)*W-1:0] got, input logic [(N+1)*W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [W-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   // one full N=4 row observed cycle by cycle; cycle 1 is the cycle after the accept edge
   task automatic row4(input logic [W-1:0] b, input logic ten, input logic [(N+1)*W-1:0] exp,
                       input logic started, input logic [7:0] stray,
                       input logic chain, input logic [W-1:0] nb, input logic [N*W-1:0] na);
      logic any_t, any_c;
      logic we_exp;
      any_t = 1'b0;
      any_c = 1'b0;
      if (!started) begin
         i4.start = 1'b1; i4.b_word = b; i4.t_en = ten;
         @(negedge clk);
      end
      i4.start = 1'b0;
      for (int c = 1; c <= N + 3; c++) begin
         we_exp = (c >= 2 && c <= N + 2);
         check("r_we", i4.r_we, we_exp);
         if (we_exp) begin
            check("r_addr", i4.r_addr, c - 2);
            check("r_wdata", i4.r_wdata, exp[(c-2)*W +: W]);
         end
         check("busy", i4.busy, c <= N + 2);
         check("done", i4.done, c == N + 3);
         check("a_rd_en", i4.a_rd_en, c <= N);
         if (c == N + 3) check("carry_out", i4.carry_out, exp[N*W +: W]);
         any_t |= i4.t_rd_en;
         any_c |= (i4.ma_last_c != '0);
         i4.start = stray[c];
         if (stray[c]) i4.b_word = 5;
         if (c == N + 3 && chain) begin
            i4.start = 1'b1; i4.b_word = nb; i4.t_en = 1'b0; A4 = na;
         end
         @(negedge clk);
      end
      i4.start = 1'b0;
      check("t_rd_en_any", any_t, ten);
      if (b == '0) check("last_c_zero", any_c, 1'b0);
   endtask
   task automatic row4_rand();
      logic [(N+1)*W-1:0] aw, bw, tw;
      logic [W-1:0] b;
      logic ten;
      A4 = {rnd(), rnd(), rnd(), rnd()};
      T4 = {rnd(), rnd(), rnd(), rnd()};
      b = ($urandom_range(0, 7) == 0) ? M : rnd();
      ten = 1'($urandom_range(0, 1));
      aw = A4; bw = b; tw = ten ? T4 : '0;
      row4(b, ten, aw * bw + tw, 1'b0, 8'd0, 1'b0, '0, '0);
   endtask
   task automatic row2_rand();
      logic [3*W-1:0] aw, bw, tw, e, r;
      logic [W-1:0] b;
      logic ten;
      int n, wc;
      A2 = {rnd(), rnd()};
      T2 = {rnd(), rnd()};
      b = rnd();
      ten = 1'($urandom_range(0, 1));
      aw = A2; bw = b; tw = ten ? T2 : '0;
      e = aw * bw + tw;
      r = '0;
      n = 0;
      wc = 0;
      i2.start = 1'b1; i2.b_word = b; i2.t_en = ten;
      @(negedge clk);
      i2.start = 1'b0;
      while (!i2.done && n < 20) begin
         if (i2.r_we) begin
            r[int'(i2.r_addr)*W +: W] = i2.r_wdata;
            wc++;
         end
         @(negedge clk);
         n++;
      end
      check("n2_done_cycle", n, 4);
      check("n2_writes", wc, 3);
      check("n2_result", r, e);
      check("n2_carry_out", i2.carry_out, e[2*W +: W]);
   endtask
   initial begin
      i4.start = 1'b0; i4.t_en = 1'b0; i4.b_word = '0;
      i2.start = 1'b0; i2.t_en = 1'b0; i2.b_word = '0;
      A4 = '0; T4 = '0; A2 = '0; T2 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", i4.busy, 1'b0);
      check("rst_done", i4.done, 1'b0);
      check("rst_r_we", i4.r_we, 1'b0);
      check("rst_a_rd_en", i4.a_rd_en, 1'b0);
      check("rst_t_rd_en", i4.t_rd_en, 1'b0);
      check("rst_carry_out", i4.carry_out, '0);
      rst_n = 1'b1;
      @(negedge clk);
      A4 = {4{128'd1}};
      T4 = {4{128'd9}};
      row4(2, 1'b0, {128'd0, 128'd2, 128'd2, 128'd2, 128'd2}, 1'b0, 8'd0, 1'b0, '0, '0);
      A4 = {4{M}};
      T4 = {4{M}};
      row4(M, 1'b1, {M, M, M, M, 128'd0}, 1'b0, 8'd0, 1'b0, '0, '0);
      // reset at the edge ending cycle 3 of a row
      i4.start = 1'b1; i4.b_word = 7; i4.t_en = 1'b1;
      @(negedge clk);
      i4.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", i4.busy, 1'b0);
      check("abort_r_we", i4.r_we, 1'b0);
      check("abort_done", i4.done, 1'b0);
      check("abort_carry_out", i4.carry_out, '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort_idle_we", i4.r_we, 1'b0);
         check("abort_idle_done", i4.done, 1'b0);
      end
      A4 = {4{128'd3}};
      T4 = {128'd8, 128'd7, 128'd6, 128'd5};
      row4(0, 1'b1, {128'd0, 128'd8, 128'd7, 128'd6, 128'd5}, 1'b0, 8'd0, 1'b0, '0, '0);
      A4 = {4{128'd1}};
      row4(2, 1'b0, {128'd0, 128'd2, 128'd2, 128'd2, 128'd2}, 1'b0, 8'b0010_1000,
           1'b1, 128'd3, {128'd0, 128'd0, 128'd0, 128'd1});
      row4(3, 1'b0, {128'd0, 128'd0, 128'd0, 128'd0, 128'd3}, 1'b1, 8'd0, 1'b0, '0, '0);
      for (int k = 0; k < 1000; k++) row4_rand();
      for (int k = 0; k < 200; k++) row2_rand();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
